// File: rtl/alu_pkg.sv
// Shared ALU package: operation codes used by the ALU, the datapath and the
// multiply sequencer, plus the sequencer state encoding and default width.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_OP_ADD = 4'b0000,
        ALU_OP_LUI = 4'b1000,
        ALU_OP_ORI = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle 32x32 MUL controller (low word of the product). It borrows the
// shared ALU as an adder and runs one shift-and-add step per cycle.
// Optional build macro ALU_MUL_EARLY_TERM_EN: leave RUN as soon as no set
// multiplier bits remain, instead of always iterating XLEN times.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int         XLEN       = XLEN_DEFAULT,
    parameter logic [3:0] ALU_ADD_OP = ALU_OP_ADD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [XLEN-1:0] multiplicand_i,
    input  logic [XLEN-1:0] multiplier_i,
    input  logic [XLEN-1:0] alu_result_i,
    output logic            alu_sel_o,
    output logic [3:0]      alu_operation_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_COUNT = CW'(XLEN - 1);

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] product_q, product_d;
    logic            alu_sel_q, alu_sel_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            last_iter;

    // Decide whether the current RUN step is the final one.
    always_comb begin
`ifdef ALU_MUL_EARLY_TERM_EN
        last_iter = (count_q == LAST_COUNT) || ((mplier_q >> 1) == '0);
`else
        last_iter = (count_q == LAST_COUNT);
`endif
    end

    // Next-state, shift-register and counter updates for the FSM.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            SEQ_IDLE: begin
                if (start_i) begin
                    acc_d    = '0;
                    mcand_d  = multiplicand_i;
                    mplier_d = multiplier_i;
                    count_d  = '0;
                    state_d  = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                acc_d    = alu_result_i;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (last_iter) begin
                    product_d = alu_result_i;
                    state_d   = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // Status outputs are registered, so derive them from the upcoming state.
    always_comb begin
        alu_sel_d = (state_d == SEQ_RUN);
        busy_d    = (state_d != SEQ_IDLE);
        done_d    = (state_d == SEQ_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEQ_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
            alu_sel_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
            alu_sel_q <= alu_sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // ALU drive: add the partial product only while RUN owns the ALU.
    always_comb begin
        alu_operation_o = ALU_ADD_OP;
        alu_a_o         = '0;
        alu_b_o         = '0;
        if (state_q == SEQ_RUN) begin
            alu_a_o = acc_q;
            alu_b_o = mplier_q[0] ? mcand_q : '0;
        end
    end

    assign alu_sel_o = alu_sel_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: shared ALU modelled as an adder,
// results and cycle counts predicted from plain multiplication.
module tb_alu_mul_sequencer;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [31:0] multiplicand_i;
    logic [31:0] multiplier_i;
    logic [31:0] alu_result_i;
    logic        alu_sel_o;
    logic [3:0]  alu_operation_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] product_o;

    int checks   = 0;
    int failures = 0;

    alu_mul_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .multiplicand_i  (multiplicand_i),
        .multiplier_i    (multiplier_i),
        .alu_result_i    (alu_result_i),
        .alu_sel_o       (alu_sel_o),
        .alu_operation_o (alu_operation_o),
        .alu_a_o         (alu_a_o),
        .alu_b_o         (alu_b_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .product_o       (product_o)
    );

    // Shared ALU behaves as a combinational adder.
    assign alu_result_i = alu_a_o + alu_b_o;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Expected number of RUN cycles for a given multiplier.
    function automatic int runLength(input logic [31:0] b);
        int n;
`ifdef ALU_MUL_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < 32; i++)
            if (b[i]) n = i + 1;
`else
        n = 32;
`endif
        return n;
    endfunction

    // Launch one multiply and follow it to completion. If intrudeAt > 0, a
    // second start with other operands is pulsed at that observed cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input int intrudeAt, input logic [31:0] ia,
                                 input logic [31:0] ib);
        logic [31:0] expProd;
        logic [63:0] wide;
        logic [31:0] expA;
        logic [31:0] expB;
        logic [31:0] lowBits;
        int          expRun;
        int          cycles;
        int          selCycles;
        int          doneCount;
        bit          seenDone;
        expProd   = a * b;
        expRun    = runLength(b);
        cycles    = 0;
        selCycles = 0;
        doneCount = 0;
        seenDone  = 0;
        start_i        = 1'b1;
        multiplicand_i = a;
        multiplier_i   = b;
        while (!seenDone && cycles < 80) begin
            @(negedge clk);
            cycles++;
            start_i        = (cycles == intrudeAt) ? 1'b1 : 1'b0;
            multiplicand_i = (cycles == intrudeAt) ? ia : ~a;
            multiplier_i   = (cycles == intrudeAt) ? ib : ~b;
            checkOutput("busy_during_op", {63'd0, busy_o}, 64'd1);
            if (alu_sel_o) begin
                lowBits = (selCycles == 0) ? 32'd0 : (32'hFFFF_FFFF >> (32 - selCycles));
                wide    = {32'd0, a} * {32'd0, (b & lowBits)};
                expA    = wide[31:0];
                expB    = b[selCycles] ? (a << selCycles) : 32'd0;
                checkOutput("alu_a_partial", {32'd0, alu_a_o}, {32'd0, expA});
                checkOutput("alu_b_addend", {32'd0, alu_b_o}, {32'd0, expB});
                selCycles++;
            end
            if (done_o) begin
                seenDone = 1;
                doneCount++;
            end
        end
        start_i = 1'b0;
        checkOutput("done_within_budget", {63'd0, seenDone}, 64'd1);
        checkOutput("done_latency", 64'(cycles), 64'(expRun + 1));
        checkOutput("alu_sel_cycles", 64'(selCycles), 64'(expRun));
        checkOutput("product", {32'd0, product_o}, {32'd0, expProd});
        @(negedge clk);
        checkOutput("done_single_pulse", {63'd0, done_o}, 64'd0);
        checkOutput("busy_idle", {63'd0, busy_o}, 64'd0);
        checkOutput("alu_a_idle", {32'd0, alu_a_o}, 64'd0);
        checkOutput("alu_b_idle", {32'd0, alu_b_o}, 64'd0);
        checkOutput("product_held", {32'd0, product_o}, {32'd0, expProd});
    endtask

    // Start an operation, reset it at RUN cycle 17 and confirm it is abandoned.
    task automatic resetMidRun();
        int doneCount;
        doneCount      = 0;
        start_i        = 1'b1;
        multiplicand_i = 32'h0000_1234;
        multiplier_i   = 32'h8000_FFFF;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        checkOutput("busy_before_reset", {63'd0, busy_o}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_busy", {63'd0, busy_o}, 64'd0);
        checkOutput("reset_alu_sel", {63'd0, alu_sel_o}, 64'd0);
        checkOutput("reset_done", {63'd0, done_o}, 64'd0);
        checkOutput("reset_product", {32'd0, product_o}, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_o) doneCount++;
        end
        checkOutput("no_done_after_reset", 64'(doneCount), 64'd0);
        checkOutput("idle_after_reset", {63'd0, busy_o}, 64'd0);
    endtask

    // Main sequence: reset checks, directed cases, then randomized operands.
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        reset          = 1'b1;
        start_i        = 1'b0;
        multiplicand_i = 32'd0;
        multiplier_i   = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", {63'd0, busy_o}, 64'd0);
        checkOutput("rst_done", {63'd0, done_o}, 64'd0);
        checkOutput("rst_alu_sel", {63'd0, alu_sel_o}, 64'd0);
        checkOutput("rst_product", {32'd0, product_o}, 64'd0);
        checkOutput("rst_alu_a", {32'd0, alu_a_o}, 64'd0);
        checkOutput("rst_alu_b", {32'd0, alu_b_o}, 64'd0);
        checkOutput("alu_op_add", {60'd0, alu_operation_o}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(32'd3, 32'd5, 0, 32'd0, 32'd0);
        checkOutput("p_3x5", {32'd0, product_o}, 64'h0000_000F);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd0, 32'd0);
        checkOutput("p_ffx_ff", {32'd0, product_o}, 64'h0000_0001);
        applyStimulus(32'hFFFF_FFF9, 32'd6, 0, 32'd0, 32'd0);
        checkOutput("p_m7x6", {32'd0, product_o}, 64'hFFFF_FFD6);
        applyStimulus(32'h8000_0000, 32'd2, 0, 32'd0, 32'd0);
        checkOutput("p_overflow", {32'd0, product_o}, 64'h0000_0000);
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF1, 11, 32'd7, 32'd7);
        applyStimulus(32'd1234, 32'd1, 0, 32'd0, 32'd0);
        applyStimulus(32'd1234, 32'd0, 0, 32'd0, 32'd0);
        applyStimulus(32'd1234, 32'h8000_0000, 0, 32'd0, 32'd0);

        resetMidRun();
        applyStimulus(32'd2, 32'd9, 0, 32'd0, 32'd0);
        checkOutput("p_2x9", {32'd0, product_o}, 64'h0000_0012);

        for (int n = 0; n < 20; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            applyStimulus(ra, rb, 0, 32'd0, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that runs a 32x32 MUL (low 32 bits of the product) by sequencing the shared 32-bit ALU through shift-and-add iterations.
- Sits beside the single-cycle datapath.
- While busy it owns the ALU operand/operation mux, via alu_sel_o; it drives ALU_Operation, A and B, and captures ALU_Result each cycle.
- Signed and unsigned operands give an identical low word, so one mode serves both.

Parameters:
- XLEN, 32, operand/result width; must match ALU width.
- ALU_ADD_OP, 4'b0000, ALU operation code driven during iterations; equals the ALU ADD/ADDI code.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  request; sampled only in IDLE.
- multiplicand_i  input  XLEN  operand A; captured with start_i.
- multiplier_i  input  XLEN  operand B; captured with start_i.
- alu_result_i  input  XLEN  ALU_Result from the shared ALU (combinational path).
- alu_sel_o  output  1  high: datapath mux routes sequencer outputs onto the ALU.
- alu_operation_o  output  4  ALU_Operation drive.
- alu_a_o  output  XLEN  ALU A drive.
- alu_b_o  output  XLEN  ALU B drive.
- busy_o  output  1  high in RUN and DONE.
- done_o  output  1  one-cycle completion pulse.
- product_o  output  XLEN  registered result; held until the next accepted start.

Behaviour:
- One clock, clk. Reset is synchronous, active-high, on the port reset.
- Reset values: state=IDLE; alu_sel_o=0, busy_o=0, done_o=0; product_o=0; internal acc, mcand, mplier and count all 0.
- alu_operation_o is constantly ALU_ADD_OP.
- alu_a_o/alu_b_o are 0 whenever not in RUN.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 at edge N: load acc=0, mcand=multiplicand_i, mplier=multiplier_i, count=0; go to RUN.
  - Otherwise stay.
- RUN:
  - alu_sel_o=1, alu_a_o=acc, alu_b_o = mplier[0] ? mcand : 0.
  - Each edge: acc<=alu_result_i; mcand<=mcand<<1 (zero fill, bits beyond XLEN dropped); mplier<=mplier>>1 (logical); count<=count+1.
  - When count==XLEN-1 at the edge: product_o<=alu_result_i, go to DONE.
  - count width is clog2(XLEN); no wrap occurs before exit.
- DONE:
  - done_o=1, busy_o=1, alu_sel_o=0.
  - Next edge: go to IDLE.
- Latency (base build): start at edge N; RUN occupies edges N+1..N+32; done_o high in the cycle after edge N+32; back in IDLE after edge N+33.
- Arithmetic is modulo 2^XLEN. The ALU Zero output is unused.
- start_i while busy_o=1 (RUN or DONE) is ignored; no queueing. A new start is accepted only in IDLE, so back-to-back ops take at least 34 cycles apart.
- Operands are captured at start; later input changes have no effect.
- Reset mid-operation: state returns to IDLE at that edge; product_o=0; no done_o pulse.
- alu_result_i is trusted as combinational A+B in the same cycle; the sequencer does not check it.

Optional Feature:
- Macro ALU_MUL_EARLY_TERM_EN.
- Defined: in RUN, the block exits to DONE at any edge where the next mplier value (mplier>>1) is 0 or count==XLEN-1, capturing product_o<=alu_result_i.
  - RUN length is max(1, index of highest set multiplier bit + 1).
  - A multiplier of 0 takes 1 RUN cycle.
- Undefined: fixed XLEN RUN cycles regardless of operands.
- Result values are identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - ALU operation codes (ADD/ADDI 4'b0000, LUI 4'b1000, ORI 4'b1001);
  - sequencer state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - XLEN default.
- ALU and datapath reuse the same op codes from the package.
- No sub-module; FSM, shift registers and counter live in one module.
- The ALU operand mux stays in the datapath, controlled by alu_sel_o.

Test Plan:
- 3 x 5, base build -> done_o pulses exactly 33 cycles after the start edge; product_o=0x0000000F; alu_sel_o high exactly 32 cycles.
- 0xFFFFFFFF x 0xFFFFFFFF -> product_o=0x00000001.
- 0xFFFFFFF9 (-7) x 6 -> product_o=0xFFFFFFD6; 0x80000000 x 2 -> 0x00000000 (overflow drops).
- start_i pulsed at RUN cycle 10 with new operands -> ignored; product_o = first operation's result; one done_o only.
- reset asserted at RUN cycle 17 -> next cycle IDLE, busy_o=0, product_o=0, no done_o; a subsequent 2 x 9 gives 0x12.
- ALU_MUL_EARLY_TERM_EN defined:
  - 1234 x 1 -> 1 RUN cycle, product_o=1234;
  - x 0 -> 1 RUN cycle, product_o=0;
  - x 0x80000000 -> 32 RUN cycles.
